ti_adc_deskew_retimer: RTL and testbench
========================================

Name: ti_adc_deskew_retimer

Overview:
Parametrised successor to the plain TI-ADC output retimer. It retimes all time-interleaved slice outputs into the `clk` domain and applies a programmable per-slice cycle delay for slice alignment. It also converts from a selectable input code format to two's complement, adds a per-slice signed offset correction with saturation, and flags valid output. It sits between the TI-ADC slice array and the DSP equaliser front end.

Parameters:
Nadc, 8, ADC code width in bits (input and output)
Nti, 5, number of time-interleaved slices
Ndly, 3, maximum extra per-slice delay in clk cycles (>=1)
Noff, 6, signed offset-correction width (Noff<=Nadc)

Ports:
clk  input  1  clock; all state on rising edge
rstn  input  1  asynchronous active-low reset
en  input  1  pipeline enable; 0 freezes all data registers
mode  input  2  input code format: 0 offset-binary, 1 two's complement, 2 sign-magnitude, 3 reserved (treated as 0)
dly_sel  input  [Nti-1:0][$clog2(Ndly+1)-1:0]  per-slice extra delay, 0..Ndly; values >Ndly clamp to Ndly
ofs  input  signed [Noff-1:0] x Nti  per-slice offset added after conversion
sat_clr  input  1  clears all sticky saturation flags
din  input  [Nadc-1:0] x Nti  raw slice outputs
dout  output  signed [Nadc-1:0] x Nti  retimed, aligned, corrected samples
dout_valid  output  1  dout holds fully filled pipeline data
sat_flag  output  Nti  sticky per-slice saturation indicator

Behaviour:
- Clock is `clk`; reset is `rstn`, asynchronous and active-low. While rstn=0: all delay-line registers, dout=0, dout_valid=0, sat_flag=0, fill counter=0, dly_sel shadow=0. Reset asserted mid-stream clears everything immediately, with no waiting for a clk edge.
- Stage 0 (capture): with en=1, each edge registers din[i] into tap0 of slice i's delay line (depth Ndly+1) and shifts tapN→tapN+1.
- Tap select: sample = tap[dly_sel[i]], after clamping.
- Stage 1 (convert+correct, registered into dout):
  - mode 0: invert MSB (din − 2^(Nadc-1)).
  - mode 1: pass through.
  - mode 2: MSB is sign, low Nadc-1 bits are magnitude, result is negated if sign=1; −0 (MSB=1, magnitude=0) gives 0.
  - Converted value plus sign-extended ofs[i] is computed at Nadc+1 bits, then saturated to [−2^(Nadc-1), 2^(Nadc-1)−1].
- Latency: din to dout = 2 + dly_sel[i] cycles, with en held high.
- sat_flag[i] is set on any edge (en=1) where slice i's sum was clipped. sat_clr=1 clears all flags. If a clear and a set land on the same edge, clear wins; a new clip on a later edge sets the flag again.
- Fill counter (0..Ndly+2):
  - Resets to 0 on rstn, on any edge with en=0, and on any edge where registered dly_sel differs from its shadow (the shadow then updates).
  - Otherwise increments while en=1 and saturates at Ndly+2.
  - dout_valid=1 iff counter==Ndly+2, registered, so it asserts Ndly+2 enabled edges after a restart.
- en=0: data registers and sat_flag hold. dout_valid drops on the next edge.
- mode changes take effect on the next edge with no fill restart. The bench ignores the one cycle of mixed-format data.

Decomposition:
- Shared package ti_adc_pkg:
  - typedef enum for mode (TI_FMT_OFFBIN, TI_FMT_TWOS, TI_FMT_SIGNMAG, TI_FMT_RSVD).
  - Saturation/convert functions parametrised on width.
  - Localparams for fill target and delay-select width.
- One sub-module, ti_adc_slice_dly: the per-slice delay line plus tap mux (params Nadc, Ndly; ports clk, rstn, en, din, dly_sel, dout). It is instantiated Nti times in a generate loop. Conversion, offset and valid logic stay in the top module.

Test Plan:
1. Reset: rstn=0 mid-stream with din=8'hA5 → dout=0, dout_valid=0, sat_flag=0 immediately, without a clk edge. Release → dout_valid=1 after 5 edges (Ndly=3).
2. Offset-binary, dly_sel=0, ofs=0: din 8'h80/8'hFF/8'h00 → dout 0/127/−128, each 2 cycles later.
3. Deskew: dly_sel[2]=3, others 0, all slices pulse 8'hC0 for one cycle at edge k (else 8'h80) → slices 0,1,3,4 show 64 at k+2 and slice 2 at k+5. The dly_sel write drops dout_valid for 5 edges.
4. Saturation: mode 0, din[1]=8'hFF, ofs[1]=+5 → dout[1]=127, sat_flag[1]=1. din[3]=8'h00, ofs[3]=−3 → −128, sat_flag[3]=1. sat_clr pulse with no clip → flags 0. sat_clr coincident with clip → flag 0 that edge, 1 on the next.
5. Sign-magnitude: mode 2, din 8'h85 → −5, 8'h05 → 5, 8'h80 → 0, 8'hFF with ofs=−1 → −128 (no clip).
6. Enable gating: en=0 for 3 cycles mid-stream → dout holds its last value and dout_valid=0 after one edge. en=1 → valid returns 5 edges later with no dropped or duplicated samples in the held data.

Source files
------------

// File: rtl/ti_adc_pkg.sv
// Shared types and helpers for the TI-ADC deskew retimer: code formats,
// width-generic conversion and saturation, and fill/delay-select sizing.
package ti_adc_pkg;

  typedef enum logic [1:0] {
    TI_FMT_OFFBIN  = 2'd0,
    TI_FMT_TWOS    = 2'd1,
    TI_FMT_SIGNMAG = 2'd2,
    TI_FMT_RSVD    = 2'd3
  } ti_fmt_e;

  localparam int TI_NDLY_DEF = 3;
  localparam int TI_FILL_DEF = TI_NDLY_DEF + 32'sd2;
  localparam int TI_DSW_DEF  = $clog2(TI_NDLY_DEF + 32'sd1);

  function automatic int ti_fill_target(input int ndly);
    return ndly + 32'sd2;
  endfunction

  function automatic int ti_dsel_width(input int ndly);
    return $clog2(ndly + 32'sd1);
  endfunction

  // Raw w-bit code (0..2^w-1) to its signed value; reserved format decodes as offset-binary.
  function automatic int ti_conv(input int code, input int w, input ti_fmt_e fmt);
    int half;
    int mag;
    half = 32'sd1 <<< (w - 32'sd1);
    mag  = code & (half - 32'sd1);
    case (fmt)
      TI_FMT_TWOS:    ti_conv = (code >= half) ? code - (half <<< 1) : code;
      TI_FMT_SIGNMAG: ti_conv = (code >= half) ? -mag : mag;
      default:        ti_conv = code - half;
    endcase
  endfunction

  function automatic int ti_sat(input int v, input int w);
    int hi;
    int lo;
    hi = (32'sd1 <<< (w - 32'sd1)) - 32'sd1;
    lo = -(32'sd1 <<< (w - 32'sd1));
    if (v > hi) begin
      ti_sat = hi;
    end else if (v < lo) begin
      ti_sat = lo;
    end else begin
      ti_sat = v;
    end
  endfunction

endpackage

// File: rtl/ti_adc_slice_dly.sv
// One slice's capture delay line (depth Ndly+1) with a clamped tap selector.
module ti_adc_slice_dly
  import ti_adc_pkg::*;
#(
  parameter int Nadc = 8,
  parameter int Ndly = TI_NDLY_DEF
) (
  input  logic                            clk,
  input  logic                            rstn,
  input  logic                            en,
  input  logic [Nadc-1:0]                 din,
  input  logic [ti_dsel_width(Ndly)-1:0]  dly_sel,
  output logic [Nadc-1:0]                 dout
);

  localparam int DSW = ti_dsel_width(Ndly);
  localparam logic [DSW-1:0] DMAX = DSW'(Ndly);

  logic [Nadc-1:0] tap_r [Ndly+1];
  logic [DSW-1:0]  sel_s;

  // Capture into tap 0 and shift older samples down the line
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int k = 0; k <= Ndly; k++) tap_r[k] <= '0;
    end else if (en) begin
      tap_r[0] <= din;
      for (int k = 1; k <= Ndly; k++) tap_r[k] <= tap_r[k-1];
    end
  end

  // Tap mux; out-of-range selects clamp to the deepest tap
  always_comb begin
    if (dly_sel > DMAX) begin
      sel_s = DMAX;
    end else begin
      sel_s = dly_sel;
    end
    dout = tap_r[sel_s];
  end

endmodule

// File: rtl/ti_adc_deskew_retimer.sv
// Retimes and deskews TI-ADC slice outputs, converts to two's complement,
// applies saturating per-slice offset correction and tracks pipeline fill.
module ti_adc_deskew_retimer
  import ti_adc_pkg::*;
#(
  parameter int Nadc = 8,
  parameter int Nti  = 5,
  parameter int Ndly = TI_NDLY_DEF,
  parameter int Noff = 6
) (
  input  logic                                     clk,
  input  logic                                     rstn,
  input  logic                                     en,
  input  logic [1:0]                               mode,
  input  logic [Nti-1:0][ti_dsel_width(Ndly)-1:0]  dly_sel,
  input  logic [Nti-1:0][Noff-1:0]                 ofs,
  input  logic                                     sat_clr,
  input  logic [Nti-1:0][Nadc-1:0]                 din,
  output logic [Nti-1:0][Nadc-1:0]                 dout,
  output logic                                     dout_valid,
  output logic [Nti-1:0]                           sat_flag
);

  localparam int DSW  = ti_dsel_width(Ndly);
  localparam int FILL = ti_fill_target(Ndly);
  localparam int CW   = $clog2(FILL + 32'sd1);
  localparam logic [CW-1:0] FILL_C = CW'(FILL);

  logic [Nti-1:0][DSW-1:0]  dly_r;
  logic [Nti-1:0][DSW-1:0]  dly_sh_r;
  logic [Nti-1:0][Nadc-1:0] tap_s;
  logic [Nti-1:0][Nadc-1:0] res_s;
  logic [Nti-1:0]           clip_s;
  logic [CW-1:0]            fill_r;
  logic [CW-1:0]            fill_next_s;
  int                       conv_v;
  int                       wide_v;
  int                       sat_v;

  for (genvar g = 0; g < Nti; g++) begin : g_slice
    ti_adc_slice_dly #(
      .Nadc (Nadc),
      .Ndly (Ndly)
    ) u_dly (
      .clk     (clk),
      .rstn    (rstn),
      .en      (en),
      .din     (din[g]),
      .dly_sel (dly_r[g]),
      .dout    (tap_s[g])
    );
  end

  // Stage-1 datapath; the int-wide sum cannot overflow since Noff<=Nadc
  always_comb begin
    res_s  = '0;
    clip_s = '0;
    conv_v = 32'sd0;
    wide_v = 32'sd0;
    sat_v  = 32'sd0;
    for (int i = 0; i < Nti; i++) begin
      conv_v    = ti_conv(int'(tap_s[i]), Nadc, ti_fmt_e'(mode));
      wide_v    = conv_v + int'($signed(ofs[i]));
      sat_v     = ti_sat(wide_v, Nadc);
      clip_s[i] = (sat_v != wide_v);
      res_s[i]  = Nadc'(sat_v);
    end
  end

  // Fill restarts on a stall or whenever the registered delay select moves
  always_comb begin
    if (!en || (dly_r != dly_sh_r)) begin
      fill_next_s = '0;
    end else if (fill_r == FILL_C) begin
      fill_next_s = fill_r;
    end else begin
      fill_next_s = fill_r + CW'(1'b1);
    end
  end

  // Delay-select register, its shadow, fill counter and valid flag
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      dly_r      <= '0;
      dly_sh_r   <= '0;
      fill_r     <= '0;
      dout_valid <= 1'b0;
    end else begin
      dly_r      <= dly_sel;
      dly_sh_r   <= dly_r;
      fill_r     <= fill_next_s;
      dout_valid <= (fill_next_s == FILL_C);
    end
  end

  // Output samples and sticky clip flags; a clear beats a same-edge clip
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      dout     <= '0;
      sat_flag <= '0;
    end else begin
      if (en) dout <= res_s;
      for (int i = 0; i < Nti; i++) begin
        if (sat_clr) begin
          sat_flag[i] <= 1'b0;
        end else if (en && clip_s[i]) begin
          sat_flag[i] <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ti_adc_deskew_retimer.sv
// Scoreboard bench: a queue-based behavioural model predicts every edge's
// outputs; a monitor pops and compares them after each rising edge.
module tb_ti_adc_deskew_retimer;

  localparam int NTI  = 5;
  localparam int NDLY = 3;

  typedef struct packed {
    logic [NTI-1:0][7:0] d;
    logic                v;
    logic [NTI-1:0]      f;
  } exp_t;

  logic                 clk;
  logic                 rstn;
  logic                 en;
  logic [1:0]           mode;
  logic [NTI-1:0][1:0]  dly_sel;
  logic [NTI-1:0][5:0]  ofs;
  logic                 sat_clr;
  logic [NTI-1:0][7:0]  din;
  logic [NTI-1:0][7:0]  dout;
  logic                 dout_valid;
  logic [NTI-1:0]       sat_flag;

  int errs   = 0;
  int checks = 0;

  exp_t sbq [$];
  int   q [NTI][$];
  logic [NTI-1:0][7:0] md;
  logic [NTI-1:0]      mf;
  int                  vcnt;
  logic [NTI-1:0][1:0] p1;
  logic [NTI-1:0][1:0] p2;

  ti_adc_deskew_retimer #(.Nadc(8), .Nti(NTI), .Ndly(NDLY), .Noff(6)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .en         (en),
    .mode       (mode),
    .dly_sel    (dly_sel),
    .ofs        (ofs),
    .sat_clr    (sat_clr),
    .din        (din),
    .dout       (dout),
    .dout_valid (dout_valid),
    .sat_flag   (sat_flag)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, want, $time);
    end
  endtask

  function automatic int ref_conv(input int code, input int m);
    if (m == 2) return (code >= 128) ? -(code - 128) : code;
    if (m == 1) return (code >= 128) ? code - 256 : code;
    return code - 128;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NTI; i++) begin
      q[i].delete();
      for (int k = 0; k <= NDLY; k++) q[i].push_back(0);
    end
    md = '0;
    mf = '0;
    vcnt = 0;
    p1 = '0;
    p2 = '0;
  endtask

  // Predict the result of the coming edge, queue it, then advance one cycle.
  task automatic step();
    exp_t e;
    if (!rstn) begin
      model_reset();
    end else begin
      for (int i = 0; i < NTI; i++) begin
        int d;
        int s;
        int r;
        logic clip;
        d = (int'(p1[i]) > NDLY) ? NDLY : int'(p1[i]);
        s = ref_conv(q[i][d], int'(mode)) + int'($signed(ofs[i]));
        clip = (s > 127) || (s < -128);
        r = (s > 127) ? 127 : ((s < -128) ? -128 : s);
        if (en) md[i] = r[7:0];
        if (sat_clr) mf[i] = 1'b0;
        else if (en && clip) mf[i] = 1'b1;
        if (en) begin
          q[i].push_front(int'(din[i]));
          void'(q[i].pop_back());
        end
      end
      if (!en || (p1 != p2)) vcnt = 0;
      else if (vcnt < NDLY + 2) vcnt++;
      p2 = p1;
      p1 = dly_sel;
    end
    e.d = md;
    e.v = (vcnt == NDLY + 2);
    e.f = mf;
    sbq.push_back(e);
    @(posedge clk);
    #4;
  endtask

  // Monitor: compare each edge's outputs against the queued prediction
  always @(posedge clk) begin
    exp_t e;
    #2;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      chk("sb_dout", 64'(dout), 64'(e.d));
      chk("sb_valid", 64'(dout_valid), 64'(e.v));
      chk("sb_sat_flag", 64'(sat_flag), 64'(e.f));
    end
  end

  initial begin
    rstn = 1'b0; en = 1'b1; mode = 2'd0; dly_sel = '0; ofs = '0; sat_clr = 1'b0; din = '0;
    model_reset();
    @(posedge clk);
    #4;
    step();
    rstn = 1'b1;

    // Offset-binary basics
    din = {NTI{8'h80}}; step(); step();
    chk("obin_80", 64'(dout), 64'({NTI{8'h00}}));
    din = {NTI{8'hFF}}; step(); step();
    chk("obin_ff", 64'(dout), 64'({NTI{8'h7F}}));
    din = {NTI{8'h00}}; step(); step();
    chk("obin_00", 64'(dout), 64'({NTI{8'h80}}));
    chk("valid_after_fill", 64'(dout_valid), 64'(1'b1));

    // Deskew of slice 2 by three cycles
    din = {NTI{8'h80}}; dly_sel[2] = 2'd3;
    step(); step();
    chk("dly_change_valid_drop", 64'(dout_valid), 64'(1'b0));
    repeat (4) step();
    chk("dly_still_filling", 64'(dout_valid), 64'(1'b0));
    din = {NTI{8'hC0}}; step();
    chk("dly_refill_valid", 64'(dout_valid), 64'(1'b1));
    din = {NTI{8'h80}}; step();
    chk("dsk_s0_k2", 64'(dout[0]), 64'h40);
    chk("dsk_s2_k2", 64'(dout[2]), 64'h00);
    step(); step(); step();
    chk("dsk_s2_k5", 64'(dout[2]), 64'h40);
    chk("dsk_s4_k5", 64'(dout[4]), 64'h00);
    dly_sel = '0; repeat (6) step();

    // Saturation and sticky flags
    din[1] = 8'hFF; ofs[1] = 6'd5; din[3] = 8'h00; ofs[3] = 6'h3D;
    step(); step();
    chk("sat_hi_val", 64'(dout[1]), 64'h7F);
    chk("sat_lo_val", 64'(dout[3]), 64'h80);
    chk("sat_flags_set", 64'(sat_flag & 5'b01010), 64'(5'b01010));
    din = {NTI{8'h80}}; ofs = '0; step(); step();
    sat_clr = 1'b1; step(); sat_clr = 1'b0;
    chk("sat_clr_no_clip", 64'(sat_flag), 64'(5'b00000));
    din[1] = 8'hFF; ofs[1] = 6'd5; step();
    sat_clr = 1'b1; step();
    chk("sat_clr_wins", 64'(sat_flag[1]), 64'(1'b0));
    sat_clr = 1'b0; step();
    chk("sat_reset_next", 64'(sat_flag[1]), 64'(1'b1));

    // Sign-magnitude
    mode = 2'd2; ofs = '0; din = {NTI{8'h85}}; sat_clr = 1'b1; step(); sat_clr = 1'b0; step();
    chk("sm_neg5", 64'(dout[0]), 64'hFB);
    din = {NTI{8'h05}}; step(); step();
    chk("sm_pos5", 64'(dout[0]), 64'h05);
    din = {NTI{8'h80}}; step(); step();
    chk("sm_negzero", 64'(dout[0]), 64'h00);
    din = {NTI{8'hFF}}; ofs = {NTI{6'h3F}}; step(); step();
    chk("sm_min_noclip", 64'(dout[0]), 64'h80);
    chk("sm_min_flag", 64'(sat_flag[0]), 64'(1'b0));

    // Randomised traffic
    for (int n = 0; n < 300; n++) begin
      for (int i = 0; i < NTI; i++) din[i] = 8'($urandom);
      en = ($urandom_range(0, 15) != 0);
      if ($urandom_range(0, 19) == 0) mode = 2'($urandom);
      if ($urandom_range(0, 9) == 0) for (int i = 0; i < NTI; i++) ofs[i] = 6'($urandom);
      if ($urandom_range(0, 39) == 0) for (int i = 0; i < NTI; i++) dly_sel[i] = 2'($urandom);
      sat_clr = ($urandom_range(0, 29) == 0);
      step();
    end
    sat_clr = 1'b0;

    // Enable gating mid-stream
    en = 1'b1; mode = 2'd0;
    repeat (8) begin
      for (int i = 0; i < NTI; i++) din[i] = 8'($urandom);
      step();
    end
    en = 1'b0; step();
    chk("en_off_valid", 64'(dout_valid), 64'(1'b0));
    step(); step();
    en = 1'b1;
    repeat (4) begin
      for (int i = 0; i < NTI; i++) din[i] = 8'($urandom);
      step();
    end
    chk("en_refill_4", 64'(dout_valid), 64'(1'b0));
    step();
    chk("en_refill_5", 64'(dout_valid), 64'(1'b1));

    // Asynchronous reset mid-stream
    din = {NTI{8'hA5}}; din[1] = 8'hFF; ofs[1] = 6'd5; step(); step();
    rstn = 1'b0;
    #1;
    chk("rst_async_dout", 64'(dout), 64'h0);
    chk("rst_async_valid", 64'(dout_valid), 64'h0);
    chk("rst_async_flags", 64'(sat_flag), 64'h0);
    step(); step();
    dly_sel = '0; rstn = 1'b1;
    repeat (4) step();
    chk("rst_fill_4", 64'(dout_valid), 64'(1'b0));
    step();
    chk("rst_fill_5", 64'(dout_valid), 64'(1'b1));

    for (int k = 0; k < 10 && sbq.size() > 0; k++) @(posedge clk);
    chk("sb_drain", 64'(sbq.size()), 64'h0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
